bus_traffic_gen: RTL and testbench
==================================

Name: bus_traffic_gen

Overview:
- On-chip traffic generator that sits directly upstream of the bus top level.
- It drives master 1's device-side ready/valid interface: wdata, addr, valid, rw_mode in; rdata, ready out of the top.
- On start it issues NUM_TXN writes of a deterministic pattern, then reads the same addresses back and compares each byte.
- It reports pass/fail, error count, first failing address and timeout, for LED/demo display.

Parameters:
ADDR_WIDTH, 16, device address width (matches bus top).
DATA_WIDTH, 8, data width.
NUM_TXN, 16, transactions per phase (1..255).
BASE_ADDR, 16'h0000, first target address.
ADDR_STRIDE, 1, address increment per transaction.
DATA_SEED, 8'hA5, pattern seed.
TIMEOUT_CYCLES, 1024, maximum cycles allowed per transaction.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  level; sampled only in IDLE/DONE
d_wdata  out  DATA_WIDTH  write data to master port
d_rdata  in  DATA_WIDTH  read data from master port
d_addr  out  ADDR_WIDTH  transaction address
d_valid  out  1  request valid
d_ready  in  1  master port ready/idle
d_mode  out  1  0 read, 1 write
busy  out  1  test running
done  out  1  test finished (held until next start)
pass  out  1  valid when done: no mismatches and no timeout
err_count  out  8  mismatch count, saturates at 255
first_bad_addr  out  ADDR_WIDTH  address of first mismatch, 0 if none
timeout  out  1  a transaction exceeded TIMEOUT_CYCLES

Behaviour:
- Reset values (asserted asynchronously, mid-operation included): all outputs 0, FSM to IDLE, index 0.
- Pattern for index i:
  - addr_i = BASE_ADDR + i*ADDR_STRIDE, mod 2^ADDR_WIDTH (wraps silently).
  - data_i = DATA_SEED + i, mod 2^DATA_WIDTH.
- States: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE.
- IDLE/DONE:
  - start=1 → clear done, pass, err_count, first_bad_addr, timeout; set busy; i=0; go WR_REQ.
  - start is ignored while busy.
- WR_REQ:
  - Drive d_valid=1, d_mode=1, d_addr=addr_i, d_wdata=data_i, all held stable until the handshake (d_valid & d_ready in the same cycle).
  - Next cycle: d_valid=0, go WR_WAIT.
- WR_WAIT / RD_WAIT, completion:
  - Set seen_busy when d_ready=0.
  - Transaction completes on the first cycle with d_ready=1 and seen_busy=1. seen_busy clears at each new request.
  - If d_ready never drops, completion is taken 2 cycles after the handshake.
- After a write completes: i==NUM_TXN-1 → i=0, go RD_REQ; else i+1, go WR_REQ.
- RD_REQ: same as WR_REQ with d_mode=0 and d_wdata=0.
- RD_WAIT:
  - On completion, sample d_rdata and compare with data_i.
  - On mismatch: err_count+1 (saturating at 255); capture first_bad_addr only if err_count was 0.
  - Last index → DONE; else next RD_REQ.
- Timeout:
  - Cycle counter clears on entering any REQ state and counts in REQ and WAIT states.
  - At TIMEOUT_CYCLES: timeout=1, d_valid=0, go DONE.
- DONE: busy=0, done=1, pass = (err_count==0) & ~timeout. Outputs hold until the next start.
- Request issue gap: d_valid is never high in consecutive transactions without at least one intervening deasserted cycle.
- d_mode and d_addr hold their last value when d_valid=0. The bench checks them only while d_valid=1.
- No combinational path from d_ready or d_rdata to any output.

Test Plan:
- Reset, then start pulse with NUM_TXN=4, BASE_ADDR=0x0010, against a correct memory model (ready drops 3 cycles per transaction) → writes A5,A6,A7,A8 to 0x0010..0x0013, then 4 reads; done=1, pass=1, err_count=0.
- Model corrupts the read at 0x0012 (returns 0x00) → err_count=1, first_bad_addr=0x0012, pass=0.
- Model holds d_ready=0 forever after the 2nd write, TIMEOUT_CYCLES=64 → timeout=1 exactly 64 cycles after that request, d_valid=0, done=1, pass=0.
- Wrap case: BASE_ADDR=0xFFFE, NUM_TXN=4, DATA_SEED=0xFE → addresses FFFE,FFFF,0000,0001; data FE,FF,00,01; pass=1.
- rst asserted while in RD_WAIT → all outputs 0 in the same cycle; a later start reruns the full test and passes.
- start held high through a whole run → no restart while busy; a new run begins the cycle after DONE is entered (done pulses high for 1 cycle).

Source files
------------

// File: rtl/bus_traffic_gen.sv
// Traffic generator: writes a deterministic pattern through a ready/valid master port,
// reads it back, and reports mismatch count, first failing address and timeout.
module bus_traffic_gen #(
  parameter int unsigned           ADDR_WIDTH     = 16,
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           NUM_TXN        = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned           ADDR_STRIDE    = 1,
  parameter logic [DATA_WIDTH-1:0] DATA_SEED      = DATA_WIDTH'(8'hA5),
  parameter int unsigned           TIMEOUT_CYCLES = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic [DATA_WIDTH-1:0] o_d_wdata,
  input  logic [DATA_WIDTH-1:0] i_d_rdata,
  output logic [ADDR_WIDTH-1:0] o_d_addr,
  output logic                  o_d_valid,
  input  logic                  i_d_ready,
  output logic                  o_d_mode,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [7:0]            o_err_count,
  output logic [ADDR_WIDTH-1:0] o_first_bad_addr,
  output logic                  o_timeout
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StWrReq, StWrWait, StRdReq, StRdWait, StDone} state_e;

  state_e                r_state, w_state_nxt;
  logic [7:0]            r_idx, w_idx_nxt;
  logic                  r_seen_busy, w_seen_busy_nxt;
  logic                  r_wait1, w_wait1_nxt;
  logic [CntW-1:0]       r_cyc, w_cyc_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic                  r_mode, w_mode_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_pass, w_pass_nxt;
  logic [7:0]            r_err, w_err_nxt;
  logic [ADDR_WIDTH-1:0] r_fba, w_fba_nxt;
  logic                  r_timeout, w_timeout_nxt;

  logic                  w_txn_done;
  logic                  w_last;
  logic                  w_tmo;
  logic                  w_active;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_exp_data;

  // Completion needs an observed busy phase, or falls back to the 2nd cycle after handshake.
  assign w_txn_done = i_d_ready & (r_seen_busy | r_wait1);
  assign w_last     = (r_idx == 8'(NUM_TXN - 1));
  assign w_tmo      = (r_cyc == CntW'(TIMEOUT_CYCLES - 1));
  assign w_active   = (r_state == StWrReq) || (r_state == StWrWait) ||
                      (r_state == StRdReq) || (r_state == StRdWait);
  assign w_exp_data = DATA_SEED + DATA_WIDTH'(r_idx);

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_seen_busy_nxt = r_seen_busy;
    w_wait1_nxt     = r_wait1;
    w_cyc_nxt       = r_cyc;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_mode_nxt      = r_mode;
    w_busy_nxt      = r_busy;
    w_done_nxt      = r_done;
    w_pass_nxt      = r_pass;
    w_err_nxt       = r_err;
    w_fba_nxt       = r_fba;
    w_timeout_nxt   = r_timeout;
    w_load          = 1'b0;

    unique case (r_state)
      StIdle, StDone: begin
        if (i_start) begin
          w_state_nxt   = StWrReq;
          w_idx_nxt     = '0;
          w_busy_nxt    = 1'b1;
          w_done_nxt    = 1'b0;
          w_pass_nxt    = 1'b0;
          w_err_nxt     = '0;
          w_fba_nxt     = '0;
          w_timeout_nxt = 1'b0;
        end
      end
      StWrReq, StRdReq: begin
        w_cyc_nxt = r_cyc + CntW'(1);
        if (i_d_ready) begin
          w_state_nxt = (r_state == StWrReq) ? StWrWait : StRdWait;
          w_wait1_nxt = 1'b0;
        end
      end
      StWrWait: begin
        w_cyc_nxt       = r_cyc + CntW'(1);
        w_seen_busy_nxt = r_seen_busy | ~i_d_ready;
        w_wait1_nxt     = 1'b1;
        if (w_txn_done) begin
          w_idx_nxt   = w_last ? 8'd0 : r_idx + 8'd1;
          w_state_nxt = w_last ? StRdReq : StWrReq;
        end
      end
      StRdWait: begin
        w_cyc_nxt       = r_cyc + CntW'(1);
        w_seen_busy_nxt = r_seen_busy | ~i_d_ready;
        w_wait1_nxt     = 1'b1;
        if (w_txn_done) begin
          if (i_d_rdata != w_exp_data) begin
            if (r_err != 8'hFF) w_err_nxt = r_err + 8'd1;
            if (r_err == 8'd0)  w_fba_nxt = r_addr;
          end
          if (w_last) begin
            w_state_nxt = StDone;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt   = r_idx + 8'd1;
            w_state_nxt = StRdReq;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    if (w_active && w_tmo) begin
      w_state_nxt   = StDone;
      w_timeout_nxt = 1'b1;
      w_busy_nxt    = 1'b0;
      w_done_nxt    = 1'b1;
    end

    // Entering a request state latches the new address/data and restarts the per-txn trackers.
    w_load = (w_state_nxt != r_state) && ((w_state_nxt == StWrReq) || (w_state_nxt == StRdReq));
    if (w_load) begin
      w_cyc_nxt       = '0;
      w_seen_busy_nxt = 1'b0;
      w_wait1_nxt     = 1'b0;
      w_mode_nxt      = (w_state_nxt == StWrReq);
      w_addr_nxt      = BASE_ADDR + ADDR_WIDTH'(32'(w_idx_nxt) * ADDR_STRIDE);
      w_wdata_nxt     = (w_state_nxt == StWrReq) ? DATA_SEED + DATA_WIDTH'(w_idx_nxt) : '0;
    end

    if ((w_state_nxt == StDone) && (r_state != StDone)) begin
      w_pass_nxt = (w_err_nxt == 8'd0) && !w_timeout_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_seen_busy <= 1'b0;
      r_wait1     <= 1'b0;
      r_cyc       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mode      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err       <= '0;
      r_fba       <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_seen_busy <= w_seen_busy_nxt;
      r_wait1     <= w_wait1_nxt;
      r_cyc       <= w_cyc_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_mode      <= w_mode_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_pass      <= w_pass_nxt;
      r_err       <= w_err_nxt;
      r_fba       <= w_fba_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign o_d_valid        = (r_state == StWrReq) || (r_state == StRdReq);
  assign o_d_mode         = r_mode;
  assign o_d_addr         = r_addr;
  assign o_d_wdata        = r_wdata;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_pass           = r_pass;
  assign o_err_count      = r_err;
  assign o_first_bad_addr = r_fba;
  assign o_timeout        = r_timeout;

endmodule

// File: tb/tb_bus_traffic_gen.sv
// Bench for bus_traffic_gen: two instances (normal base and wrap-around base) each driven by a
// memory model with a 3-cycle busy phase; requests are checked against a scoreboard queue.
module tb_bus_traffic_gen;

  typedef struct packed {
    logic        mode;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } txn_t;

  logic             clk;
  logic             rst;
  logic             start0;
  logic             start1;
  logic [1:0]       valid_v, mode_v, busy_v, done_v, pass_v, tmo_v;
  logic [1:0][15:0] addr_v, fba_v;
  logic [1:0][7:0]  wdata_v, errc_v;
  logic             corrupt_en;
  logic             hang_en;
  int               cyc = 0;
  int               req2_cyc;
  int               n_chk = 0;
  int               n_fail = 0;
  txn_t             exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic       ready;
    logic [7:0] rdata;
    logic [7:0] mem [65536];

    bus_traffic_gen #(
      .ADDR_WIDTH     (16),
      .DATA_WIDTH     (8),
      .NUM_TXN        (4),
      .BASE_ADDR      (g == 0 ? 16'h0010 : 16'hFFFE),
      .ADDR_STRIDE    (1),
      .DATA_SEED      (g == 0 ? 8'hA5 : 8'hFE),
      .TIMEOUT_CYCLES (64)
    ) u_dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_start          (g == 0 ? start0 : start1),
      .o_d_wdata        (wdata_v[g]),
      .i_d_rdata        (rdata),
      .o_d_addr         (addr_v[g]),
      .o_d_valid        (valid_v[g]),
      .i_d_ready        (ready),
      .o_d_mode         (mode_v[g]),
      .o_busy           (busy_v[g]),
      .o_done           (done_v[g]),
      .o_pass           (pass_v[g]),
      .o_err_count      (errc_v[g]),
      .o_first_bad_addr (fba_v[g]),
      .o_timeout        (tmo_v[g])
    );

    // Memory model plus request monitor: observe at negedge, update ready/rdata after posedge.
    initial begin : p_model
      int          cnt;
      int          nwr;
      bit          hang;
      bit          hs;
      bit          prev_hs;
      logic        hs_mode;
      logic [15:0] hs_addr;
      logic [7:0]  hs_wdata;
      logic [7:0]  pend;
      txn_t        e;
      ready   = 1'b1;
      rdata   = 8'h00;
      cnt     = 0;
      nwr     = 0;
      hang    = 1'b0;
      prev_hs = 1'b0;
      pend    = 8'h00;
      forever begin
        @(negedge clk);
        if (!busy_v[g]) nwr = 0;
        hs = !rst && valid_v[g] && ready;
        if (!rst && prev_hs) chk("req_gap", valid_v[g], 0);
        if (hs) begin
          hs_mode  = mode_v[g];
          hs_addr  = addr_v[g];
          hs_wdata = wdata_v[g];
          if (hang_en && hs_mode && nwr == 1) req2_cyc = cyc;
          chk("req_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("req_mode", hs_mode, e.mode);
            chk("req_addr", hs_addr, e.addr);
            chk("req_wdata", hs_wdata, e.wdata);
          end
        end
        prev_hs = hs;
        @(posedge clk);
        #1;
        if (rst) begin
          ready   = 1'b1;
          cnt     = 0;
          nwr     = 0;
          hang    = 1'b0;
          prev_hs = 1'b0;
        end else if (hs) begin
          if (hs_mode) begin
            mem[hs_addr] = hs_wdata;
            nwr++;
            if (hang_en && nwr == 2) hang = 1'b1;
          end else begin
            pend = (corrupt_en && hs_addr == 16'h0012) ? 8'h00 : mem[hs_addr];
          end
          ready = 1'b0;
          cnt   = 3;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0 && !hang) begin
            ready = 1'b1;
            rdata = pend;
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [15:0] base, input logic [7:0] seed);
    txn_t t;
    for (int i = 0; i < 4; i++) begin
      t.mode  = 1'b1;
      t.addr  = base + 16'(i);
      t.wdata = seed + 8'(i);
      exp_q.push_back(t);
    end
    for (int i = 0; i < 4; i++) begin
      t.mode  = 1'b0;
      t.addr  = base + 16'(i);
      t.wdata = 8'h00;
      exp_q.push_back(t);
    end
  endtask

  task automatic pulse_start(input int g);
    @(negedge clk);
    if (g == 0) start0 = 1'b1;
    else        start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    chk("busy_after_start", busy_v[g], 1);
    chk("done_cleared", done_v[g], 0);
  endtask

  task automatic wait_done(input int g);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      seen = done_v[g];
    end
    chk("done_seen", seen, 1);
  endtask

  task automatic chk_status(input int g, input logic p, input logic [7:0] e,
                            input logic [15:0] f, input logic t);
    chk("done", done_v[g], 1);
    chk("busy_at_done", busy_v[g], 0);
    chk("pass", pass_v[g], p);
    chk("err_count", errc_v[g], e);
    chk("first_bad_addr", fba_v[g], f);
    chk("timeout", tmo_v[g], t);
  endtask

  task automatic chk_zero(input int g, input string pfx);
    chk({pfx, "_valid"}, valid_v[g], 0);
    chk({pfx, "_mode"}, mode_v[g], 0);
    chk({pfx, "_addr"}, addr_v[g], 0);
    chk({pfx, "_wdata"}, wdata_v[g], 0);
    chk({pfx, "_busy"}, busy_v[g], 0);
    chk({pfx, "_done"}, done_v[g], 0);
    chk({pfx, "_pass"}, pass_v[g], 0);
    chk({pfx, "_err"}, errc_v[g], 0);
    chk({pfx, "_fba"}, fba_v[g], 0);
    chk({pfx, "_tmo"}, tmo_v[g], 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : p_main
    bit seen;
    rst        = 1'b1;
    start0     = 1'b0;
    start1     = 1'b0;
    corrupt_en = 1'b0;
    hang_en    = 1'b0;
    req2_cyc   = 0;
    repeat (3) @(negedge clk);
    chk_zero(0, "rst0");
    chk_zero(1, "rst1");
    rst = 1'b0;

    // Clean run against a correct memory.
    push_exp(16'h0010, 8'hA5);
    pulse_start(0);
    wait_done(0);
    chk_status(0, 1'b1, 8'd0, 16'h0000, 1'b0);
    chk("queue_empty_a", exp_q.size(), 0);

    // One corrupted read at 0x0012.
    corrupt_en = 1'b1;
    push_exp(16'h0010, 8'hA5);
    pulse_start(0);
    wait_done(0);
    chk_status(0, 1'b0, 8'd1, 16'h0012, 1'b0);
    chk("queue_empty_b", exp_q.size(), 0);
    corrupt_en = 1'b0;

    // Ready held low after the 2nd write: timeout 64 cycles after that request.
    hang_en = 1'b1;
    push_exp(16'h0010, 8'hA5);
    pulse_start(0);
    wait_done(0);
    chk("tmo_latency", 32'(cyc - req2_cyc), 64);
    chk("valid_after_tmo", valid_v[0], 0);
    chk_status(0, 1'b0, 8'd0, 16'h0000, 1'b1);
    exp_q.delete();
    hang_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Address and data wrap-around.
    push_exp(16'hFFFE, 8'hFE);
    pulse_start(1);
    wait_done(1);
    chk_status(1, 1'b1, 8'd0, 16'h0000, 1'b0);
    chk("queue_empty_d", exp_q.size(), 0);

    // Reset asserted while waiting on a read, then a full rerun.
    push_exp(16'h0010, 8'hA5);
    pulse_start(0);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      seen = valid_v[0] && !mode_v[0];
    end
    chk("rd_req_seen", seen, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_zero(0, "midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    push_exp(16'h0010, 8'hA5);
    pulse_start(0);
    wait_done(0);
    chk_status(0, 1'b1, 8'd0, 16'h0000, 1'b0);
    chk("queue_empty_e", exp_q.size(), 0);

    // Start held high: no restart while busy, immediate restart out of DONE.
    push_exp(16'h0010, 8'hA5);
    push_exp(16'h0010, 8'hA5);
    @(negedge clk);
    start0 = 1'b1;
    wait_done(0);
    chk_status(0, 1'b1, 8'd0, 16'h0000, 1'b0);
    @(negedge clk);
    chk("restart_busy", busy_v[0], 1);
    chk("done_one_cycle", done_v[0], 0);
    start0 = 1'b0;
    wait_done(0);
    chk_status(0, 1'b1, 8'd0, 16'h0000, 1'b0);
    chk("queue_empty_f", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
